// File: rtl/rtc_pkg.sv
// Shared constants, state encoding and BCD validation for the time-of-day counter.
package rtc_pkg;

    localparam int unsigned BCD_W = 8;
    localparam int unsigned MODE_W = 4;

    localparam logic [MODE_W-1:0] SET_CODE_DEF = 4'b0100;
    localparam logic [BCD_W-1:0]  BCD_MAX_H    = 8'h23;
    localparam logic [BCD_W-1:0]  BCD_MAX_MS   = 8'h59;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SET  = 2'd1,
        LOAD = 2'd2
    } state_e;

    // Both nibbles must be decimal digits and the value must not exceed max.
    function automatic logic bcd_valid(input logic [BCD_W-1:0] v, input logic [BCD_W-1:0] max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit packed-BCD counter that wraps at MAX_BCD and flags the wrap as carry_out.
module bcd_mod_counter
    import rtc_pkg::*;
#(
    parameter logic [BCD_W-1:0] MAX_BCD = BCD_MAX_MS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             load,
    input  logic [BCD_W-1:0] load_data,
    output logic [BCD_W-1:0] value,
    output logic             carry_out
);

    // Combinational so the next digit pair advances on the same edge.
    assign carry_out = inc && (value == MAX_BCD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            value <= '0;
        end else if (load) begin
            value <= load_data;
        end else if (inc) begin
            if (value == MAX_BCD) begin
                value <= '0;
            end else if (value[3:0] == 4'd9) begin
                value <= {value[7:4] + 4'd1, 4'd0};
            end else begin
                value <= {value[7:4], value[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_time_counter.sv
// HH:MM:SS BCD time-of-day counter with 1 Hz prescaler, set-mode freeze and validated load.
module rtc_time_counter
    import rtc_pkg::*;
#(
    parameter int unsigned        CLK_HZ   = 1000,
    parameter logic [MODE_W-1:0]  SET_CODE = SET_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] enable,
    input  logic [BCD_W-1:0]  set_h,
    input  logic [BCD_W-1:0]  set_m,
    input  logic [BCD_W-1:0]  set_s,
    output logic [BCD_W-1:0]  h,
    output logic [BCD_W-1:0]  m,
    output logic [BCD_W-1:0]  s,
    output logic              tick,
    output logic              load_err
);

    localparam int unsigned       PRE_W    = $clog2(CLK_HZ);
    localparam logic [PRE_W-1:0]  PRE_TERM = PRE_W'(CLK_HZ - 1);

    state_e           state, state_nxt;
    logic [PRE_W-1:0] prescaler, prescaler_nxt;
    logic             tick_nxt, load_err_nxt;
    logic             inc_c, load_c, set_mode_c, load_valid_c;
    logic             s_carry, m_carry, day_wrap_unused;

    assign set_mode_c   = (enable == SET_CODE);
    assign load_valid_c = bcd_valid(set_h, BCD_MAX_H) && bcd_valid(set_m, BCD_MAX_MS)
                       && bcd_valid(set_s, BCD_MAX_MS);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= RUN;
            prescaler <= '0;
            tick      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            state     <= state_nxt;
            prescaler <= prescaler_nxt;
            tick      <= tick_nxt;
            load_err  <= load_err_nxt;
        end
    end

    // Entering set mode wins over a terminal-count tick on the same edge.
    always_comb begin
        state_nxt     = state;
        prescaler_nxt = prescaler;
        tick_nxt      = 1'b0;
        load_err_nxt  = load_err;
        inc_c         = 1'b0;
        load_c        = 1'b0;
        case (state)
            RUN: begin
                if (set_mode_c) begin
                    state_nxt     = SET;
                    prescaler_nxt = '0;
                end else if (prescaler == PRE_TERM) begin
                    prescaler_nxt = '0;
                    tick_nxt      = 1'b1;
                    inc_c         = 1'b1;
                end else begin
                    prescaler_nxt = prescaler + PRE_W'(1);
                end
            end
            SET: begin
                prescaler_nxt = '0;
                if (!set_mode_c) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                prescaler_nxt = '0;
                load_c        = load_valid_c;
                load_err_nxt  = !load_valid_c;
                state_nxt     = set_mode_c ? SET : RUN;
            end
            default: begin
                state_nxt     = RUN;
                prescaler_nxt = '0;
            end
        endcase
    end

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS)) u_sec (
        .clk(clk), .rst(rst), .inc(inc_c), .load(load_c),
        .load_data(set_s), .value(s), .carry_out(s_carry)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS)) u_min (
        .clk(clk), .rst(rst), .inc(s_carry), .load(load_c),
        .load_data(set_m), .value(m), .carry_out(m_carry)
    );

    bcd_mod_counter #(.MAX_BCD(BCD_MAX_H)) u_hour (
        .clk(clk), .rst(rst), .inc(m_carry), .load(load_c),
        .load_data(set_h), .value(h), .carry_out(day_wrap_unused)
    );

endmodule

// File: tb/tb_rtc_time_counter.sv
// Self-checking bench: directed vector table, corner sequence and randomized run vs a seconds-of-day model.
module tb_rtc_time_counter;

    localparam int unsigned CLK_HZ = 4;
    localparam logic [3:0]  SETC   = 4'b0100;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] enable;
    logic [7:0] set_h, set_m, set_s;
    logic [7:0] h, m, s;
    logic       tick, load_err;

    int n_tests = 0;
    int n_fail  = 0;

    rtc_time_counter #(.CLK_HZ(CLK_HZ), .SET_CODE(SETC)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .set_h(set_h), .set_m(set_m), .set_s(set_s),
        .h(h), .m(m), .s(s), .tick(tick), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Reference model: time kept as seconds since midnight.
    int m_secs  = 0;
    int m_phase = 0;
    int m_mode  = 0;   // 0 running, 1 frozen, 2 loading
    bit m_tick  = 1'b0;
    bit m_err   = 1'b0;

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    function automatic bit field_ok(input logic [7:0] v, input int max);
        int tens, units;
        tens  = int'(v[7:4]);
        units = int'(v[3:0]);
        return (tens < 10) && (units < 10) && (tens * 10 + units <= max);
    endfunction

    function automatic int dec(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    task automatic model_step(input logic r, input logic [3:0] en,
                              input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss);
        m_tick = 1'b0;
        if (!r) begin
            m_secs = 0; m_phase = 0; m_mode = 0; m_err = 1'b0;
        end else if (m_mode == 0) begin
            if (en == SETC) begin
                m_mode = 1; m_phase = 0;
            end else if (m_phase == CLK_HZ - 1) begin
                m_phase = 0; m_tick = 1'b1;
                m_secs = (m_secs + 1) % 86400;
            end else begin
                m_phase++;
            end
        end else if (m_mode == 1) begin
            if (en != SETC) m_mode = 2;
        end else begin
            if (field_ok(sh, 23) && field_ok(sm, 59) && field_ok(ss, 59)) begin
                m_secs = dec(sh) * 3600 + dec(sm) * 60 + dec(ss);
                m_err  = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            m_phase = 0;
            m_mode  = (en == SETC) ? 1 : 0;
        end
    endtask

    function automatic logic [25:0] model_out();
        return {to_bcd(m_secs / 3600), to_bcd((m_secs / 60) % 60), to_bcd(m_secs % 60), m_tick, m_err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, compare every output.
    task automatic cyc(input logic r, input logic [3:0] en,
                       input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] ss);
        rst = r; enable = en; set_h = sh; set_m = sm; set_s = ss;
        @(posedge clk);
        model_step(r, en, sh, sm, ss);
        #1;
        check("model", 32'({h, m, s, tick, load_err}), 32'(model_out()));
    endtask

    typedef struct {
        logic       r;
        logic [3:0] en;
        logic [7:0] sh, sm, ss;
        int         ncyc;
        logic [7:0] eh, em, es;
        logic       etick, eerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [3:0] en, input logic [7:0] sh,
                                input logic [7:0] sm, input logic [7:0] ss, input int n,
                                input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                                input logic et, input logic ee);
        vec_t v;
        v.r = r; v.en = en; v.sh = sh; v.sm = sm; v.ss = ss; v.ncyc = n;
        v.eh = eh; v.em = em; v.es = es; v.etick = et; v.eerr = ee;
        return v;
    endfunction

    initial begin
        rst = 1'b0; enable = 4'h0; set_h = 8'h00; set_m = 8'h00; set_s = 8'h00;

        // Reset, first tick, set/load, invalid loads, roll-overs, enable glitch, reset in LOAD.
        vecs.push_back(mk(0, 4'h0, 8'h00, 8'h00, 8'h00, 2, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h00, 8'h00, 8'h00, 3, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h01, 1, 0));
        vecs.push_back(mk(1, 4'h0, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00, 8'h01, 0, 0));
        vecs.push_back(mk(1, SETC, 8'h12, 8'h34, 8'h56, 10, 8'h00, 8'h00, 8'h01, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h12, 8'h34, 8'h56, 1, 8'h00, 8'h00, 8'h01, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h12, 8'h34, 8'h56, 1, 8'h12, 8'h34, 8'h56, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h00, 8'h00, 8'h00, 3, 8'h12, 8'h34, 8'h56, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h00, 8'h00, 8'h00, 1, 8'h12, 8'h34, 8'h57, 1, 0));
        vecs.push_back(mk(1, SETC, 8'h24, 8'h00, 8'h00, 2, 8'h12, 8'h34, 8'h57, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h24, 8'h00, 8'h00, 2, 8'h12, 8'h34, 8'h57, 0, 1));
        vecs.push_back(mk(1, SETC, 8'h01, 8'h5A, 8'h00, 1, 8'h12, 8'h34, 8'h57, 0, 1));
        vecs.push_back(mk(1, 4'h0, 8'h01, 8'h5A, 8'h00, 2, 8'h12, 8'h34, 8'h57, 0, 1));
        vecs.push_back(mk(1, SETC, 8'h01, 8'h02, 8'h03, 1, 8'h12, 8'h34, 8'h57, 0, 1));
        vecs.push_back(mk(1, 4'h0, 8'h01, 8'h02, 8'h03, 2, 8'h01, 8'h02, 8'h03, 0, 0));
        vecs.push_back(mk(1, SETC, 8'h23, 8'h59, 8'h58, 1, 8'h01, 8'h02, 8'h03, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h23, 8'h59, 8'h58, 2, 8'h23, 8'h59, 8'h58, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h00, 8'h00, 8'h00, 4, 8'h23, 8'h59, 8'h59, 1, 0));
        vecs.push_back(mk(1, 4'h0, 8'h00, 8'h00, 8'h00, 4, 8'h00, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(1, SETC, 8'h09, 8'h59, 8'h59, 1, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h09, 8'h59, 8'h59, 2, 8'h09, 8'h59, 8'h59, 0, 0));
        vecs.push_back(mk(1, 4'hF, 8'h00, 8'h00, 8'h00, 4, 8'h10, 8'h00, 8'h00, 1, 0));
        vecs.push_back(mk(1, SETC, 8'h07, 8'h08, 8'h09, 1, 8'h10, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h07, 8'h08, 8'h09, 1, 8'h10, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, SETC, 8'h07, 8'h08, 8'h09, 1, 8'h07, 8'h08, 8'h09, 0, 0));
        vecs.push_back(mk(1, SETC, 8'h00, 8'h00, 8'h00, 8, 8'h07, 8'h08, 8'h09, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h11, 8'h11, 8'h11, 1, 8'h07, 8'h08, 8'h09, 0, 0));
        vecs.push_back(mk(0, 4'h0, 8'h11, 8'h11, 8'h11, 1, 8'h00, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 4'h0, 8'h11, 8'h11, 8'h11, 4, 8'h00, 8'h00, 8'h01, 1, 0));

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].ncyc; k++)
                cyc(vecs[i].r, vecs[i].en, vecs[i].sh, vecs[i].sm, vecs[i].ss);
            check($sformatf("vec%0d", i), 32'({h, m, s, tick, load_err}),
                  32'({vecs[i].eh, vecs[i].em, vecs[i].es, vecs[i].etick, vecs[i].eerr}));
        end

        // Entering set mode exactly at terminal count must not tick or advance time.
        cyc(0, 4'h0, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < CLK_HZ - 1; k++) cyc(1, 4'h0, 8'h00, 8'h00, 8'h00);
        cyc(1, SETC, 8'h00, 8'h00, 8'h00);
        check("set_at_term", 32'({s, tick}), 32'({8'h00, 1'b0}));
        cyc(1, 4'h0, 8'h05, 8'h00, 8'h00);
        cyc(1, 4'h0, 8'h05, 8'h00, 8'h00);
        check("load_after_term", 32'(h), 32'(8'h05));
        // Tick is a single-cycle pulse.
        for (int k = 0; k < CLK_HZ; k++) cyc(1, 4'h0, 8'h00, 8'h00, 8'h00);
        check("tick_hi", 32'({tick, s}), 32'({1'b1, 8'h01}));
        cyc(1, 4'h0, 8'h00, 8'h00, 8'h00);
        check("tick_lo", 32'({tick, s}), 32'({1'b0, 8'h01}));

        // Randomized run with long set/run phases, occasional resets and mixed valid/invalid loads.
        begin
            bit         want_set;
            logic [3:0] en_r;
            logic [7:0] rh, rm, rs;
            want_set = 1'b0;
            rh = 8'h00; rm = 8'h00; rs = 8'h00;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 11) == 0) begin
                    want_set = ~want_set;
                    if ($urandom_range(0, 1) == 0) begin
                        rh = to_bcd($urandom_range(0, 23));
                        rm = ($urandom_range(0, 2) == 0) ? 8'h59 : to_bcd($urandom_range(0, 59));
                        rs = to_bcd($urandom_range(50, 59));
                    end else begin
                        rh = 8'($urandom); rm = 8'($urandom); rs = 8'($urandom);
                    end
                end
                if (want_set) begin
                    en_r = SETC;
                end else begin
                    en_r = 4'($urandom);
                    if (en_r == SETC) en_r = 4'h0;
                end
                cyc(($urandom_range(0, 299) != 0), en_r, rh, rm, rs);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
